irrigation_valve_sequencer: RTL and testbench



---
 rtl/irrigation_pkg.sv | 37 +++
 rtl/irrigation_tick_counter.sv | 36 +++
 rtl/irrigation_valve_sequencer.sv | 134 +++++++++++++
 tb/tb_irrigation_valve_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irrigation_pkg                                                       |
// | Shared type codes, phase encodings and defaults for the sequencer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package irrigation_pkg;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_ASP  = 2'b01;
  localparam logic [1:0] TYPE_GOT  = 2'b10;
  localparam logic [1:0] TYPE_MIX  = 2'b11;

  localparam int ASP_SECONDS_DEFAULT  = 22;
  localparam int SETTLE_TICKS_DEFAULT = 2;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'b000,
    PH_SETTLE  = 3'b001,
    PH_ASP     = 3'b010,
    PH_MIX_ASP = 3'b011,
    PH_MIX_GOT = 3'b100,
    PH_GOT     = 3'b101,
    PH_FAULT   = 3'b110
  } phase_e;

  // First valve-open phase reached once settling completes for a target.
  function automatic phase_e run_phase(input logic [1:0] target);
    case (target)
      TYPE_MIX: return PH_MIX_ASP;
      TYPE_GOT: return PH_GOT;
      default:  return PH_ASP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/irrigation_tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irrigation_tick_counter                                              |
// | Saturating tick counter with clear and match against a run-time limit.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module irrigation_tick_counter
  import irrigation_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick_en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             match
);

  localparam logic [CNT_W-1:0] c_all_ones = {CNT_W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick_en && (count != c_all_ones)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign match = (count == limit);

endmodule
`default_nettype wire

// File: rtl/irrigation_valve_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irrigation_valve_sequencer                                           |
// | Drives valves/pump from the irrigation type with settling gaps and   |
// | low-water fault. IRRIG_FAULT_LATCH_EN makes FAULT sticky until reset.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module irrigation_valve_sequencer
  import irrigation_pkg::*;
#(
  parameter int ASP_SECONDS  = ASP_SECONDS_DEFAULT,
  parameter int SETTLE_TICKS = SETTLE_TICKS_DEFAULT,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       type_of_irrigation_state,
  input  logic             tick,
  input  logic             level_low,
  output logic             valve_asp,
  output logic             valve_got,
  output logic             pump_on,
  output logic             fault,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] elapsed
);

  localparam logic [CNT_W-1:0] c_settle_lim = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] c_asp_lim    = CNT_W'(ASP_SECONDS - 1);

  phase_e           r_state;
  phase_e           w_next;
  logic [1:0]       r_target;
  logic [1:0]       w_next_target;
  logic             w_cnt_clear;
  logic             w_cnt_inc;
  logic             w_cnt_match;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_limit;
  logic             w_next_asp;
  logic             w_next_got;

  assign w_limit = (r_state == PH_SETTLE) ? c_settle_lim : c_asp_lim;

  irrigation_tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_cnt_clear),
    .tick_en (w_cnt_inc),
    .limit   (w_limit),
    .count   (w_cnt),
    .match   (w_cnt_match)
  );

  always_comb begin
    w_next        = r_state;
    w_next_target = r_target;
    w_cnt_clear   = 1'b0;
    w_cnt_inc     = 1'b0;
    case (r_state)
      PH_IDLE: begin
        if (type_of_irrigation_state != TYPE_NONE) begin
          w_next        = PH_SETTLE;
          w_next_target = type_of_irrigation_state;
          w_cnt_clear   = 1'b1;
        end
      end
      PH_FAULT: begin
`ifdef IRRIG_FAULT_LATCH_EN
        w_next = PH_FAULT;
`else
        if (!level_low && (type_of_irrigation_state == TYPE_NONE)) begin
          w_next = PH_IDLE;
        end
`endif
      end
      default: begin
        if (level_low) begin
          w_next      = PH_FAULT;
          w_cnt_clear = 1'b1;
        end else if (type_of_irrigation_state == TYPE_NONE) begin
          w_next      = PH_IDLE;
          w_cnt_clear = 1'b1;
        end else if (type_of_irrigation_state != r_target) begin
          // Keep the open valve when the new type needs that same valve next.
          w_next_target = type_of_irrigation_state;
          w_cnt_clear   = 1'b1;
          if ((r_state == PH_MIX_GOT) && (type_of_irrigation_state == TYPE_GOT)) begin
            w_next = PH_GOT;
          end else if ((r_state == PH_ASP) && (type_of_irrigation_state == TYPE_MIX)) begin
            w_next = PH_MIX_ASP;
          end else begin
            w_next = PH_SETTLE;
          end
        end else if (tick && ((r_state == PH_SETTLE) || (r_state == PH_MIX_ASP))) begin
          if (w_cnt_match) begin
            w_cnt_clear = 1'b1;
            w_next      = (r_state == PH_SETTLE) ? run_phase(r_target) : PH_MIX_GOT;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
    endcase
  end

  assign w_next_asp = (w_next == PH_ASP) || (w_next == PH_MIX_ASP);
  assign w_next_got = (w_next == PH_MIX_GOT) || (w_next == PH_GOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= PH_IDLE;
      r_target  <= TYPE_NONE;
      valve_asp <= 1'b0;
      valve_got <= 1'b0;
      pump_on   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_target  <= w_next_target;
      valve_asp <= w_next_asp;
      valve_got <= w_next_got;
      pump_on   <= w_next_asp | w_next_got;
      fault     <= (w_next == PH_FAULT);
    end
  end

  assign phase   = r_state;
  assign elapsed = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_valve_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_irrigation_valve_sequencer                                        |
// | Two instances (default, and ASP_SECONDS=3/CNT_W=2) vs a rule model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_irrigation_valve_sequencer;

  localparam int P_IDLE = 0, P_SETTLE = 1, P_ASP = 2, P_MIXA = 3;
  localparam int P_MIXG = 4, P_GOT = 5, P_FAULT = 6;
  localparam int SETTLE = 2;
`ifdef IRRIG_FAULT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       level_low = 1'b0;
  logic [1:0] typ = 2'b00;

  logic       va0, vg0, pu0, fa0, va1, vg1, pu1, fa1;
  logic [2:0] ph0, ph1;
  logic [4:0] el0;
  logic [1:0] el1;

  wire [11:0] got0 = {va0, vg0, pu0, fa0, ph0, el0};
  wire [11:0] got1 = {va1, vg1, pu1, fa1, ph1, 3'b000, el1};

  int m_ph[2];
  int m_tgt[2];
  int m_cnt[2];
  int asp_lim[2] = '{22, 3};
  int cnt_max[2] = '{31, 3};
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  irrigation_valve_sequencer u_dut (
    .clk (clk), .rst_n (rst_n), .type_of_irrigation_state (typ), .tick (tick),
    .level_low (level_low), .valve_asp (va0), .valve_got (vg0), .pump_on (pu0),
    .fault (fa0), .phase (ph0), .elapsed (el0)
  );

  irrigation_valve_sequencer #(.ASP_SECONDS (3), .CNT_W (2)) u_dut_small (
    .clk (clk), .rst_n (rst_n), .type_of_irrigation_state (typ), .tick (tick),
    .level_low (level_low), .valve_asp (va1), .valve_got (vg1), .pump_on (pu1),
    .fault (fa1), .phase (ph1), .elapsed (el1)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ph[d] = P_IDLE; m_tgt[d] = 0; m_cnt[d] = 0;
    end
  endtask

  // Rule-level model: one call per rising clock edge.
  task automatic model_step(input int d);
    int t;
    int lim;
    t = int'(typ);
    if (m_ph[d] == P_IDLE) begin
      if (t != 0) begin m_tgt[d] = t; m_cnt[d] = 0; m_ph[d] = P_SETTLE; end
    end else if (m_ph[d] == P_FAULT) begin
      if (!LATCH && !level_low && t == 0) m_ph[d] = P_IDLE;
    end else if (level_low) begin
      m_ph[d] = P_FAULT; m_cnt[d] = 0;
    end else if (t == 0) begin
      m_ph[d] = P_IDLE; m_cnt[d] = 0;
    end else if (t != m_tgt[d]) begin
      m_cnt[d] = 0;
      if (m_ph[d] == P_MIXG && t == 2) m_ph[d] = P_GOT;
      else if (m_ph[d] == P_ASP && t == 3) m_ph[d] = P_MIXA;
      else m_ph[d] = P_SETTLE;
      m_tgt[d] = t;
    end else if (tick && (m_ph[d] == P_SETTLE || m_ph[d] == P_MIXA)) begin
      lim = (m_ph[d] == P_SETTLE) ? SETTLE : asp_lim[d];
      if (m_cnt[d] == lim - 1) begin
        m_cnt[d] = 0;
        if (m_ph[d] == P_MIXA) m_ph[d] = P_MIXG;
        else m_ph[d] = (m_tgt[d] == 3) ? P_MIXA : (m_tgt[d] == 2) ? P_GOT : P_ASP;
      end else if (m_cnt[d] < cnt_max[d]) begin
        m_cnt[d] = m_cnt[d] + 1;
      end
    end
  endtask

  function automatic logic [11:0] exp_vec(input int d);
    logic a;
    logic g;
    int   el;
    a  = (m_ph[d] == P_ASP) || (m_ph[d] == P_MIXA);
    g  = (m_ph[d] == P_MIXG) || (m_ph[d] == P_GOT);
    el = (m_ph[d] == P_SETTLE || m_ph[d] == P_MIXA) ? m_cnt[d] : 0;
    return {a, g, a | g, (m_ph[d] == P_FAULT), 3'(m_ph[d]), 5'(el)};
  endfunction

  task automatic cyc(input bit t);
    tick = t;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (got0 !== 12'h000 || got1 !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state dut=%h/%h exp=000/000", got0, got1);
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_asp();
    int n = 0;
    int settle_ticks = 0;
    typ = 2'b01;
    while (m_ph[0] != P_ASP && n < 100) begin
      if (ph0 == 3'b001) settle_ticks = settle_ticks + 1;
      cyc($urandom_range(0, 2) == 0);
      if (!tick && ph0 == 3'b001) settle_ticks = settle_ticks; // no-op: count only applied ticks
      n++;
      vectors++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL asp_run t=%0t dut=%h/%h exp=%h/%h", $time, got0, got1, exp_vec(0), exp_vec(1));
      end
    end
    vectors++;
    if (n >= 100 || {va0, vg0, pu0, ph0} !== {3'b101, 3'b010}) begin
      miscompares++;
      $display("FAIL asp_open phase=%b va=%b pump=%b exp phase=010 va=1 pump=1", ph0, va0, pu0);
    end
    typ = 2'b00;
    cyc(1'b0);
    vectors++;
    if ({va0, vg0, pu0, ph0} !== 6'b000000) begin
      miscompares++;
      $display("FAIL asp_close phase=%b va=%b vg=%b exp phase=000 valves=0", ph0, va0, vg0);
    end
  endtask

  task automatic test_mix();
    int n = 0;
    int max_el = 0;
    int mix_ticks = 0;
    typ = 2'b11;
    while (m_ph[0] != P_MIXG && n < 600) begin
      cyc($urandom_range(0, 2) == 0);
      n++;
      if (ph0 == 3'b011 && int'(el0) > max_el) max_el = int'(el0);
      vectors++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL mix_run t=%0t dut=%h/%h exp=%h/%h", $time, got0, got1, exp_vec(0), exp_vec(1));
      end
    end
    vectors++;
    if (n >= 600 || max_el != 21 || {va0, vg0} !== 2'b01) begin
      miscompares++;
      $display("FAIL mix_handover max_elapsed=%0d va=%b vg=%b exp max_elapsed=21 va=0 vg=1", max_el, va0, vg0);
    end
    for (int i = 0; i < 60; i++) begin
      cyc(i[0]);
      mix_ticks = mix_ticks + i[0];
      vectors++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL mix_hold t=%0t dut=%h/%h exp=%h/%h", $time, got0, got1, exp_vec(0), exp_vec(1));
      end
    end
    vectors++;
    if (ph0 !== 3'b100 || ph1 !== 3'b100) begin
      miscompares++;
      $display("FAIL mix_hold_phase after %0d ticks phase=%b/%b exp=100/100", mix_ticks, ph0, ph1);
    end
  endtask

  task automatic test_asp_to_got();
    int n = 0;
    typ = 2'b00;
    cyc(1'b0);
    typ = 2'b01;
    while (m_ph[0] != P_ASP && n < 100) begin
      cyc($urandom_range(0, 1) == 0);
      n++;
      vectors++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL a2g_asp t=%0t dut=%h/%h exp=%h/%h", $time, got0, got1, exp_vec(0), exp_vec(1));
      end
    end
    typ = 2'b10;
    n = 0;
    while (m_ph[0] != P_GOT && n < 100) begin
      cyc($urandom_range(0, 1) == 0);
      n++;
      vectors++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1) || (va0 && vg0) || (va1 && vg1)) begin
        miscompares++;
        $display("FAIL a2g_got t=%0t dut=%h/%h exp=%h/%h", $time, got0, got1, exp_vec(0), exp_vec(1));
      end
    end
    vectors++;
    if (n >= 100 || ph0 !== 3'b101 || vg0 !== 1'b1) begin
      miscompares++;
      $display("FAIL a2g_final phase=%b vg=%b exp phase=101 vg=1", ph0, vg0);
    end
  endtask

  task automatic test_fault();
    logic [2:0] exp_ph;
    level_low = 1'b1;
    typ = 2'b01;
    cyc(1'b1);
    vectors++;
    if (got0 !== exp_vec(0) || {fa0, va0, vg0, ph0} !== 6'b100110) begin
      miscompares++;
      $display("FAIL fault_enter dut=%h exp=%h fault=%b phase=%b", got0, exp_vec(0), fa0, ph0);
    end
    level_low = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(i[0]);
      vectors++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1) || ph0 !== 3'b110) begin
        miscompares++;
        $display("FAIL fault_hold dut=%h/%h exp=%h/%h", got0, got1, exp_vec(0), exp_vec(1));
      end
    end
    typ = 2'b00;
    cyc(1'b0);
    exp_ph = LATCH ? 3'b110 : 3'b000;
    vectors++;
    if (ph0 !== exp_ph || got0 !== exp_vec(0)) begin
      miscompares++;
      $display("FAIL fault_exit phase=%b exp=%b", ph0, exp_ph);
    end
    if (LATCH) begin
      rst_n = 1'b0;
      model_reset();
      @(negedge clk) rst_n = 1'b1;
    end
  endtask

  task automatic test_reset_mid_mix();
    int n = 0;
    typ = 2'b00;
    cyc(1'b0);
    typ = 2'b11;
    while (!(m_ph[0] == P_MIXA && m_cnt[0] == 10) && n < 400) begin
      cyc($urandom_range(0, 2) == 0);
      n++;
      vectors++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL rmid_run t=%0t dut=%h/%h exp=%h/%h", $time, got0, got1, exp_vec(0), exp_vec(1));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (n >= 400 || got0 !== 12'h000 || got1 !== 12'h000) begin
      miscompares++;
      $display("FAIL rmid_async dut=%h/%h exp=000/000", got0, got1);
    end
    model_reset();
    typ = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    cyc(1'b0);
    vectors++;
    if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
      miscompares++;
      $display("FAIL rmid_after dut=%h/%h exp=%h/%h", got0, got1, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) typ = 2'($urandom_range(0, 3));
      if (level_low) begin
        if ($urandom_range(0, 3) == 0) level_low = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        level_low = 1'b1;
      end
      cyc($urandom_range(0, 2) == 0);
      vectors++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1) || (va0 && vg0) || (va1 && vg1)) begin
        miscompares++;
        $display("FAIL random t=%0t dut=%h/%h exp=%h/%h", $time, got0, got1, exp_vec(0), exp_vec(1));
      end
      if (LATCH && m_ph[0] == P_FAULT && $urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_asp();
    test_mix();
    test_asp_to_got();
    test_fault();
    test_reset_mid_mix();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
